// File: rtl/serv_mac_pkg.sv
// Shared definitions for the MAC step unit and the bit-serial PC update stage.
// Holds the reset PC default, increment bit positions and the increment-select encoding.
package serv_mac_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int BIT_INC4 = 2;
    localparam int BIT_INC8 = 3;

    typedef enum logic [1:0] {
        INC_4,
        INC_8,
        INC_M4,
        INC_0
    } inc_sel_e;

    // Resolve simultaneous MAC requests: plus0 > minus4 > plus8 > default +4.
    function automatic inc_sel_e inc_select(input logic plus8, input logic minus4,
                                            input logic plus0);
        if (plus0)
            return INC_0;
        else if (minus4)
            return INC_M4;
        else if (plus8)
            return INC_8;
        else
            return INC_4;
    endfunction

endpackage

// File: rtl/serv_serial_adder.sv
// W-bit slice of a bit-serial adder; carry is held between enabled cycles and
// forced to zero on the first slice of an operation.
module serv_serial_adder #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    logic carry_q;
    logic carry_out;

    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        logic c;
        c = i_clr ? 1'b0 : carry_q;
        o_sum = '0;
        for (int j = 0; j < W; j++) begin
            o_sum[j] = i_a[j] ^ i_b[j] ^ c;
            c        = (i_a[j] & i_b[j]) | (c & (i_a[j] ^ i_b[j]));
        end
        carry_out = c;
    end

    // NOTE: sequential state is assigned with <= so all flops update together at the edge.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst)
            carry_q <= 1'b0;
        else if (i_en)
            carry_q <= carry_out;
    end

endmodule

// File: rtl/serv_mac_pc_ctrl.sv
// Bit-serial next-PC stage: +4/+8/-4/+0, jump target or trap vector, plus the
// rd write-back stream for JAL/JALR/AUIPC/LUI. W is 1 or 4.
module serv_mac_pc_ctrl
    import serv_mac_pkg::*;
#(
    parameter int          W        = 1,
    parameter int          B        = W - 1,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_pc_en,
    input  logic        i_cnt12to31,
    input  logic        i_pc_plus8,
    input  logic        i_pc_minus4,
    input  logic        i_pc_plus0,
    input  logic        i_jump,
    input  logic        i_jal_or_jalr,
    input  logic        i_utype,
    input  logic        i_pc_rel,
    input  logic        i_trap,
    input  logic [B:0]  i_imm,
    input  logic [B:0]  i_buf,
    input  logic [B:0]  i_csr_pc,
    output logic [B:0]  o_rd,
    output logic        o_bad_pc,
    output logic [31:0] o_ibus_adr
);

    logic [31:0] pc_q;
    logic [4:0]  p_q;
    logic        bad_q;

    logic        first_slice;
    inc_sel_e    inc_sel;
    logic [B:0]  pc_slice;
    logic [B:0]  inc_op;
    logic [B:0]  inc_sum;
    logic [B:0]  j_a;
    logic [B:0]  j_b;
    logic [B:0]  j_sum;
    logic [B:0]  target;
    logic        has_bit1;
    logic        target_bit1;
    logic [B:0]  next_slice;

    assign first_slice = (p_q == 5'd0);
    assign pc_slice    = pc_q[B:0];

    // A JAL/JALR always jumps, so its incrementer is free to produce PC+4 for rd.
    assign inc_sel = i_jal_or_jalr ? INC_4 : inc_select(i_pc_plus8, i_pc_minus4, i_pc_plus0);

    always_comb begin
        logic [4:0] k;
        inc_op      = '0;
        target      = j_sum;
        has_bit1    = 1'b0;
        target_bit1 = 1'b0;
        for (int j = 0; j < W; j++) begin
            k = p_q + 5'(j);
            unique case (inc_sel)
                INC_0:   inc_op[j] = 1'b0;
                INC_M4:  inc_op[j] = (k >= 5'(BIT_INC4));
                INC_8:   inc_op[j] = (k == 5'(BIT_INC8));
                default: inc_op[j] = (k == 5'(BIT_INC4));
            endcase
            if (k == 5'd0)
                target[j] = 1'b0;
            if (k == 5'd1) begin
                has_bit1    = 1'b1;
                target_bit1 = j_sum[j];
            end
        end
    end

    serv_serial_adder #(.W(W)) u_inc (
        .clk   (clk),
        .i_rst (i_rst),
        .i_en  (i_pc_en),
        .i_clr (first_slice),
        .i_a   (pc_slice),
        .i_b   (inc_op),
        .o_sum (inc_sum)
    );

    assign j_a = i_pc_rel ? pc_slice : i_buf;
    assign j_b = i_utype ? (i_imm & {W{i_cnt12to31}}) : i_imm;

    serv_serial_adder #(.W(W)) u_jump (
        .clk   (clk),
        .i_rst (i_rst),
        .i_en  (i_pc_en),
        .i_clr (first_slice),
        .i_a   (j_a),
        .i_b   (j_b),
        .o_sum (j_sum)
    );

    assign next_slice = i_trap ? i_csr_pc : (i_jump ? target : inc_sum);

    assign o_rd = i_utype ? j_sum : (i_jal_or_jalr ? inc_sum : '0);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            pc_q  <= RESET_PC;
            p_q   <= 5'd0;
            bad_q <= 1'b0;
        end else if (i_pc_en) begin
            pc_q <= {next_slice, pc_q[31:W]};
            p_q  <= p_q + 5'(W);
            // Capture overrides the clear when bit 1 lives in the first slice (W=4).
            if (first_slice)
                bad_q <= 1'b0;
            if (i_jump && has_bit1)
                bad_q <= target_bit1;
        end
    end

    assign o_bad_pc   = bad_q;
    assign o_ibus_adr = pc_q;

endmodule

// File: tb/tb_serv_mac_pc_ctrl.sv
// Self-checking bench: W=1 and W=4 instances, directed vector table, mid-update
// reset sequence and randomized updates against an arithmetic next-PC model.
module tb_serv_mac_pc_ctrl;

    localparam logic [31:0] RPC = 32'h0000_0100;

    typedef struct {
        string       name;
        bit          w4;
        bit          plus8, minus4, plus0, jump, jal, utype, rel, trap;
        logic [31:0] imm, bufv, csr;
        logic [31:0] exp_pc, exp_rd;
        logic        exp_bad;
    } vec_t;

    logic clk = 0;
    logic rst = 0;
    logic cnt12 = 0;
    logic plus8 = 0, minus4 = 0, plus0 = 0, jump = 0, jal = 0, utype = 0, rel = 0, trap = 0;

    logic        en1 = 0;
    logic [0:0]  imm1 = '0, buf1 = '0, csr1 = '0;
    logic [0:0]  rd1;
    logic        bad1;
    logic [31:0] adr1;

    logic        en4 = 0;
    logic [3:0]  imm4 = '0, buf4 = '0, csr4 = '0;
    logic [3:0]  rd4;
    logic        bad4;
    logic [31:0] adr4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serv_mac_pc_ctrl #(.W(1), .RESET_PC(RPC)) dut1 (
        .clk(clk), .i_rst(rst), .i_pc_en(en1), .i_cnt12to31(cnt12),
        .i_pc_plus8(plus8), .i_pc_minus4(minus4), .i_pc_plus0(plus0),
        .i_jump(jump), .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(rel),
        .i_trap(trap), .i_imm(imm1), .i_buf(buf1), .i_csr_pc(csr1),
        .o_rd(rd1), .o_bad_pc(bad1), .o_ibus_adr(adr1)
    );

    serv_mac_pc_ctrl #(.W(4), .RESET_PC(RPC)) dut4 (
        .clk(clk), .i_rst(rst), .i_pc_en(en4), .i_cnt12to31(cnt12),
        .i_pc_plus8(plus8), .i_pc_minus4(minus4), .i_pc_plus0(plus0),
        .i_jump(jump), .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(rel),
        .i_trap(trap), .i_imm(imm4), .i_buf(buf4), .i_csr_pc(csr4),
        .o_rd(rd4), .o_bad_pc(bad4), .o_ibus_adr(adr4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        en1 = 0;
        en4 = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
    endtask

    task automatic set_ctrl(input vec_t v);
        plus8 = v.plus8; minus4 = v.minus4; plus0 = v.plus0;
        jump = v.jump; jal = v.jal; utype = v.utype; rel = v.rel; trap = v.trap;
    endtask

    // Drive nslices enabled cycles on the selected instance and gather its rd stream.
    task automatic run_update(input bit w4, input logic [31:0] imm, input logic [31:0] bufv,
                              input logic [31:0] csr, input int nslices,
                              output logic [31:0] rd);
        int w;
        w = w4 ? 4 : 1;
        rd = '0;
        for (int s = 0; s < nslices; s++) begin
            int p;
            p = s * w;
            @(negedge clk);
            cnt12 = (p >= 12);
            if (w4) begin
                en4 = 1; imm4 = imm[p+:4]; buf4 = bufv[p+:4]; csr4 = csr[p+:4];
            end else begin
                en1 = 1; imm1 = imm[p]; buf1 = bufv[p]; csr1 = csr[p];
            end
            #1;
            if (w4) rd[p+:4] = rd4;
            else    rd[p]    = rd1;
        end
        @(negedge clk);
        en1 = 0;
        en4 = 0;
        #1;
    endtask

    task automatic model(input vec_t v, input logic [31:0] pc,
                         output logic [31:0] npc, output logic [31:0] rd, output logic bad);
        logic [31:0] sum, inc;
        sum = (v.rel ? pc : v.bufv) + (v.utype ? (v.imm & 32'hFFFF_F000) : v.imm);
        inc = v.plus0 ? 32'd0 : v.minus4 ? 32'hFFFF_FFFC : v.plus8 ? 32'd8 : 32'd4;
        npc = v.trap ? v.csr : v.jump ? (sum & ~32'd1) : pc + inc;
        rd  = v.utype ? sum : v.jal ? pc + 32'd4 : 32'd0;
        bad = v.jump & sum[1];
    endtask

    vec_t vecs[17];

    initial begin
        logic [31:0] rd, mpc1, mpc4, epc, erd;
        logic        ebad;
        vec_t        v;

        //         name        w4 p8 m4 p0 j  jal ut rel tr imm           buf  csr         pc            rd            bad
        vecs[0]  = '{"step_w1",  0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0,      32'h104,      32'h0,        0};
        vecs[1]  = '{"set200",   0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        0, 32'h200,    32'h200,      32'h0,        0};
        vecs[2]  = '{"plus8",    0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0,      32'h208,      32'h0,        0};
        vecs[3]  = '{"set200b",  0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        0, 32'h200,    32'h200,      32'h0,        0};
        vecs[4]  = '{"minus4",   0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0,      32'h1FC,      32'h0,        0};
        vecs[5]  = '{"set200c",  0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        0, 32'h200,    32'h200,      32'h0,        0};
        vecs[6]  = '{"plus0",    0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0,      32'h200,      32'h0,        0};
        vecs[7]  = '{"p0_m4",    0, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0,      32'h200,      32'h0,        0};
        vecs[8]  = '{"set1000",  1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        0, 32'h1000,   32'h1000,     32'h0,        0};
        vecs[9]  = '{"jump_neg", 1, 0, 0, 0, 1, 0, 0, 1, 0, 32'hFFFFFFF0, 0, 32'h0,      32'hFF0,      32'h0,        0};
        vecs[10] = '{"set1000b", 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        0, 32'h1000,   32'h1000,     32'h0,        0};
        vecs[11] = '{"jump_bad", 1, 0, 0, 0, 1, 0, 0, 1, 0, 32'h6,        0, 32'h0,      32'h1006,     32'h0,        1};
        vecs[12] = '{"trap_p8",  1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0,        0, 32'h80,     32'h80,       32'h0,        0};
        vecs[13] = '{"set300",   1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        0, 32'h300,    32'h300,      32'h0,        0};
        vecs[14] = '{"jal",      1, 0, 0, 0, 1, 1, 0, 1, 0, 32'h40,       0, 32'h0,      32'h340,      32'h304,      0};
        vecs[15] = '{"auipc_w1", 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h12345678, 0, 32'h0,      32'h204,      32'h12345200, 0};
        vecs[16] = '{"lui_w4",   1, 0, 0, 0, 0, 0, 1, 0, 0, 32'hABCDE123, 0, 32'h0,      32'h344,      32'hABCDE000, 0};

        do_reset();
        check("reset_adr_w1", adr1, RPC);
        check("reset_bad_w1", 32'(bad1), 32'd0);
        check("reset_adr_w4", adr4, RPC);
        check("reset_bad_w4", 32'(bad4), 32'd0);

        foreach (vecs[i]) begin
            set_ctrl(vecs[i]);
            run_update(vecs[i].w4, vecs[i].imm, vecs[i].bufv, vecs[i].csr,
                       vecs[i].w4 ? 8 : 32, rd);
            check({vecs[i].name, "_pc"}, vecs[i].w4 ? adr4 : adr1, vecs[i].exp_pc);
            check({vecs[i].name, "_rd"}, rd, vecs[i].exp_rd);
            check({vecs[i].name, "_bad"}, 32'(vecs[i].w4 ? bad4 : bad1), 32'(vecs[i].exp_bad));
        end

        // Reset in the middle of an update must restore the reset PC at once.
        do_reset();
        v = vecs[2];
        set_ctrl(v);
        run_update(0, 32'h0, 32'h0, 32'h0, 10, rd);
        rst = 1;
        #1;
        check("midrst_adr", adr1, RPC);
        @(negedge clk);
        rst = 0;
        #1;
        check("midrst_release", adr1, RPC);
        v = vecs[0];
        set_ctrl(v);
        run_update(0, 32'h0, 32'h0, 32'h0, 32, rd);
        check("midrst_step", adr1, RPC + 32'd4);

        do_reset();
        mpc1 = RPC;
        mpc4 = RPC;
        for (int n = 0; n < 40; n++) begin
            v.name   = "rand";
            v.w4     = $urandom_range(0, 1) == 1;
            v.plus8  = $urandom_range(0, 1) == 1;
            v.minus4 = $urandom_range(0, 3) == 0;
            v.plus0  = $urandom_range(0, 3) == 0;
            v.jal    = $urandom_range(0, 3) == 0;
            v.jump   = v.jal || ($urandom_range(0, 2) == 0);
            v.utype  = !v.jal && ($urandom_range(0, 3) == 0);
            v.rel    = $urandom_range(0, 1) == 1;
            v.trap   = $urandom_range(0, 5) == 0;
            v.imm    = $urandom;
            v.bufv   = (v.utype && !v.rel) ? 32'h0 : $urandom;
            v.csr    = $urandom & 32'hFFFF_FFFC;
            model(v, v.w4 ? mpc4 : mpc1, epc, erd, ebad);
            set_ctrl(v);
            run_update(v.w4, v.imm, v.bufv, v.csr, v.w4 ? 8 : 32, rd);
            check($sformatf("rand%0d_pc", n), v.w4 ? adr4 : adr1, epc);
            check($sformatf("rand%0d_rd", n), rd, erd);
            check($sformatf("rand%0d_bad", n), 32'(v.w4 ? bad4 : bad1), 32'(ebad));
            if (v.w4) mpc4 = epc;
            else      mpc1 = epc;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serv_mac_pc_ctrl.md
Name: serv_mac_pc_ctrl

Overview:
- Bit-serial program-counter update stage directly downstream of the MAC step unit.
- Consumes the MAC step unit's pc_plus8 / pc_minus4 / pc_plus0 requests together with normal jump and trap controls.
- Serially computes the next PC (+4, +8, −4, +0, jump target or trap vector), holds it in the architectural PC register, and drives the instruction bus address.
- Also produces the serial rd write-back stream for JAL/JALR/AUIPC/LUI.

Parameters:
- W, 1, bits processed per enabled cycle; legal values 1 and 4.
- B, W-1, MSB index of serial buses.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_pc_en  in  1  advance PC datapath by W bits this cycle
- i_cnt12to31  in  1  serial position is in bits 12..31 (U-type immediate window)
- i_pc_plus8  in  1  MAC step unit: next PC = PC+8
- i_pc_minus4  in  1  MAC step unit: next PC = PC−4
- i_pc_plus0  in  1  MAC step unit: next PC = PC (re-execute)
- i_jump  in  1  taken jump/branch: next PC = jump target
- i_jal_or_jalr  in  1  rd receives PC+4
- i_utype  in  1  rd receives immediate (LUI) or PC+imm (AUIPC)
- i_pc_rel  in  1  jump target base is PC (else 0, JALR uses i_buf)
- i_trap  in  1  next PC = i_csr_pc
- i_imm  in  B+1  serial immediate
- i_buf  in  B+1  serial rs1 / buffer operand
- i_csr_pc  in  B+1  serial trap vector / mepc
- o_rd  out  B+1  serial rd write data
- o_bad_pc  out  1  registered: jump target bit 1 set (misaligned)
- o_ibus_adr  out  32  current PC, parallel

Behaviour:
- Reset (async, i_rst=1):
  - PC register = RESET_PC.
  - Position counter = 0.
  - Both carry registers = 0.
  - o_bad_pc = 0.
  - o_ibus_adr = RESET_PC.
- Position counter p (5 bits, bit index of the LSB of the current W-bit slice):
  - Advances by W on each i_pc_en cycle.
  - Wraps 32→0; 32/W enabled cycles form one update.
  - i_pc_en=0 holds all state.
- Increment operand bit at index k:
  - i_pc_plus0: 0.
  - else i_pc_minus4: 1 for k≥2 (adds 0xFFFFFFFC).
  - else i_pc_plus8: 1 for k==3.
  - else (+4): 1 for k==2.
  - Priority when several are asserted: plus0 > minus4 > plus8. The inputs must be stable for the whole update.
- Incrementer: pc_slice + inc_slice + carry_inc. The carry-in is forced to 0 when p==0. carry_inc is updated each i_pc_en cycle and the final carry-out is discarded.
- Jump adder: (i_pc_rel ? pc_slice : i_buf) + (i_utype ? (i_imm & i_cnt12to31) : i_imm) + carry_j. Carry-in is forced to 0 at p==0. Bit 0 of the jump target is forced to 0 (JALR rule).
- Next-PC slice priority:
  1. i_trap → i_csr_pc.
  2. else i_jump → jump target.
  3. else incrementer.
- PC register:
  - On each i_pc_en cycle it shifts right by W, and the next-PC slice enters at bits [31:32−W].
  - After a full update it holds the new PC; o_ibus_adr is valid whenever i_pc_en=0.
- o_rd per slice:
  - i_utype: the jump adder result. With i_pc_rel=1 this is AUIPC; with i_pc_rel=0 it is LUI, where i_buf must be 0.
  - else i_jal_or_jalr: the PC+4 incrementer, computed with the MAC requests ignored.
  - else 0.
- o_bad_pc:
  - Captured from jump target bit 1 on the cycle that slice is processed, when i_jump=1.
  - Cleared at the start of the next update (p==0 with i_pc_en).
- Mid-update reset: state returns to reset values immediately; a partial PC is never exposed after reset.

Decomposition:
- Shared package (serv_mac_pkg) holds:
  - RESET_PC default.
  - Position constants BIT_INC4=2 and BIT_INC8=3.
  - The increment-select encoding (INC_4, INC_8, INC_M4, INC_0) shared with the MAC step unit.
- One natural sub-module: serv_serial_adder, a W-bit slice adder with registered carry and a synchronous clear-on-first-slice input. It is instantiated twice (incrementer and jump adder).

Test Plan:
- Reset: assert i_rst with RESET_PC=0x100, then release → o_ibus_adr=0x100, o_bad_pc=0.
- Plain step (W=1): 32 i_pc_en cycles, no requests, PC=0x100 → o_ibus_adr=0x104.
- MAC requests from PC=0x200:
  - i_pc_plus8 → 0x208.
  - i_pc_minus4 → 0x1FC.
  - i_pc_plus0 → 0x200.
  - plus0 and minus4 together → 0x200.
- Jump (W=4): PC=0x1000, i_jump, i_pc_rel, imm=0xFFFFFFF0 → o_ibus_adr=0xFF0 after 8 enables. Same jump with imm=0x6 → o_bad_pc=1, PC=0x1006.
- Trap and JAL:
  - i_trap with i_csr_pc=0x80 and i_pc_plus8 also set → PC=0x80.
  - JAL at PC=0x300 → o_rd stream = 0x304 while PC=jump target.
- Async reset asserted after 10 of 32 enables → PC=RESET_PC immediately; the next full update from reset yields RESET_PC+4.
